// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Merges the L1 I-cache miss port (read-only) and the L1 D-cache miss /
// writeback port (read/write) onto the single line interface of the unified
// L2. A request is latched into the L2-facing registers when it is granted
// and is held there until the L2 returns its completion pulse. Only the
// granted requester sees that pulse. When both sides are waiting, the side
// that was not granted last time wins.
//
// Ports
//   clk, rst                 system clock, async active-high reset
//   i_mem_read/address       I-cache line read request
//   i_mem_resp/rdata         I-cache completion pulse and line data
//   d_mem_read/write         D-cache line read / writeback request
//   d_mem_address/wdata256   D-cache address and writeback data
//   d_mem_resp/rdata         D-cache completion pulse and line data
//   l2_read/write            registered request to L2
//   l2_address/wdata256      registered address / write data to L2
//   l2_rdata, l2_resp        line data and completion pulse from L2
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request in flight; samples both L1 ports
// GRANT_I | I-cache read presented to L2, waiting for l2_resp
// GRANT_D | D-cache read or writeback presented to L2, waiting for l2_resp
// RECOVER | one dead cycle so the served L1 can drop its request
// ---------------------------------------------------------------------------
module l2_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_mem_read,
  input  logic [s_addr-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [s_line-1:0] i_mem_rdata,

  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [s_addr-1:0] d_mem_address,
  input  logic [s_line-1:0] d_mem_wdata256,
  output logic              d_mem_resp,
  output logic [s_line-1:0] d_mem_rdata,

  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata256,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // last_grant encoding: 0 = I-cache, 1 = D-cache
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              l2_read_q,    l2_read_d;
  logic              l2_write_q,   l2_write_d;
  logic [s_addr-1:0] l2_address_q, l2_address_d;
  logic [s_line-1:0] l2_wdata_q,   l2_wdata_d;

  logic pend_i;
  logic pend_d;
  logic pick_i;

  assign pend_i = i_mem_read;
  assign pend_d = d_mem_read | d_mem_write;
  // I wins when it is alone, or when both wait and D was served last.
  assign pick_i = pend_i & (~pend_d | (last_grant_q == LG_D));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d      = GRANT_I;
          last_grant_d = LG_I;
          l2_read_d    = 1'b1;
          l2_write_d   = 1'b0;
          l2_address_d = i_mem_address;
          l2_wdata_d   = '0;
        end else if (pend_d) begin
          state_d      = GRANT_D;
          last_grant_d = LG_D;
          // read and write together is treated as a writeback
          l2_read_d    = d_mem_read & ~d_mem_write;
          l2_write_d   = d_mem_write;
          l2_address_d = d_mem_address;
          l2_wdata_d   = d_mem_wdata256;
        end
      end

      GRANT_I, GRANT_D: begin
        if (l2_resp) begin
          state_d    = RECOVER;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end

      RECOVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LG_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign l2_read     = l2_read_q;
  assign l2_write    = l2_write_q;
  assign l2_address  = l2_address_q;
  assign l2_wdata256 = l2_wdata_q;

  // Completion is steered combinationally so the L1 sees it in the same
  // cycle as l2_resp; gating with rst keeps it quiet while reset is held.
  assign i_mem_resp  = ~rst & l2_resp & (state_q == GRANT_I);
  assign d_mem_resp  = ~rst & l2_resp & (state_q == GRANT_D);

  assign i_mem_rdata = l2_rdata;
  assign d_mem_rdata = l2_rdata;

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
Two-port arbiter that sits directly upstream of the unified L2 cache. It merges the L1 I-cache miss port (read-only) and the L1 D-cache miss/writeback port (read/write) onto the L2's single 256-bit line interface. Requests are latched at grant and held stable until the L2 responds. The response is routed back only to the granted requester. Ties are resolved round-robin.

Parameters:
s_line, 256, cacheline width in bits (all data buses)
s_addr, 32, address width in bits

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
i_mem_read  input  1  I-cache line read request
i_mem_address  input  s_addr  I-cache line address
i_mem_resp  output  1  I-cache completion pulse
i_mem_rdata  output  s_line  line data to I-cache
d_mem_read  input  1  D-cache line read request
d_mem_write  input  1  D-cache line writeback request
d_mem_address  input  s_addr  D-cache line address
d_mem_wdata256  input  s_line  D-cache writeback data
d_mem_resp  output  1  D-cache completion pulse
d_mem_rdata  output  s_line  line data to D-cache
l2_read  output  1  read request to L2
l2_write  output  1  write request to L2
l2_address  output  s_addr  address to L2
l2_wdata256  output  s_line  write data to L2
l2_rdata  input  s_line  line data from L2
l2_resp  input  1  L2 completion pulse (one cycle)

Behaviour:
- Reset is asynchronous and active-high. It forces state=IDLE and last_grant=I, and clears l2_read, l2_write, l2_address and l2_wdata256 to 0 immediately, without waiting for a clock edge. i_mem_resp and d_mem_resp are 0 while in reset.
- l2_read, l2_write, l2_address and l2_wdata256 are registers. i_mem_rdata and d_mem_rdata are combinational copies of l2_rdata. i_mem_resp and d_mem_resp are combinational.
- States: IDLE, GRANT_I, GRANT_D, RECOVER.
- IDLE, request pending:
  - Pending I means i_mem_read. Pending D means d_mem_read or d_mem_write.
  - Only I pending: go to GRANT_I. Latch l2_read=1, l2_write=0, l2_address=i_mem_address, l2_wdata256=0.
  - Only D pending: go to GRANT_D. Latch l2_read=d_mem_read&~d_mem_write, l2_write=d_mem_write, l2_address=d_mem_address, l2_wdata256=d_mem_wdata256.
  - Both pending: grant the side that is not last_grant.
  - Update last_grant on every grant.
  - d_mem_read and d_mem_write both high is illegal. The arbiter treats it as a write; the bench asserts it never occurs.
- Latency: a request sampled in IDLE at edge N drives the L2 request starting in cycle N+1.
- GRANT_x:
  - Latched outputs are held constant; requester input changes are ignored.
  - On l2_resp=1: assert x_mem_resp=1 in the same cycle, then go to RECOVER and clear l2_read and l2_write at that edge.
  - The non-granted resp stays 0 at all times.
- RECOVER: lasts exactly one cycle and outputs no request, then returns to IDLE. This guarantees the just-served L1 has dropped its request before it is re-sampled.
- l2_resp in IDLE or RECOVER is ignored: no resp output and no state change.
- Throughput: at best one transaction per (L2 latency + 2) cycles.
- Starvation freedom: with both sides requesting continuously, grants strictly alternate.
- Reset mid-transaction: the in-flight request is abandoned and no resp is emitted. After reset deasserts, normal arbitration resumes from IDLE with last_grant=I.

Test Plan:
1. Lone I read, i_mem_read=1, i_mem_address=0x0000_1040 at cycle 0; L2 replies at cycle 4 with rdata=0xDEAD…BEEF -> l2_read=1 and l2_address=0x1040 in cycles 1–4; i_mem_resp=1 only in cycle 4; i_mem_rdata matches; d_mem_resp=0 throughout; l2_read=0 in cycle 5.
2. Simultaneous requests after reset: I read 0x100 and D write 0x2000 with wdata all 0xA5 -> D granted first (l2_write=1, l2_wdata256 all 0xA5); after d_mem_resp, one RECOVER cycle, then l2_read=1 with l2_address=0x100.
3. Continuous contention: both sides re-request immediately after every resp for 6 transactions -> grant order D,I,D,I,D,I; no two consecutive grants to the same side.
4. Hold stability: during GRANT_D, change d_mem_address 0x2000->0x3000 and toggle d_mem_wdata256 -> l2_address stays 0x2000 and l2_wdata256 stays unchanged until resp.
5. Async reset mid-GRANT_D, with rst asserted between clock edges -> l2_write and l2_address go to 0 before the next edge; d_mem_resp stays 0; after release, a lone I read 0x40 is served with normal cycle-1 latency.
6. Spurious l2_resp=1 while IDLE with no requests -> i_mem_resp=d_mem_resp=0; state remains IDLE; the next request is served normally.
